pbit_factor_ctrl: RTL and testbench

PBIT_FACTOR_CTRL -- requirements
Module: pbit_factor_ctrl

---
 rtl/pbit_factor_pkg.sv | 15 +
 rtl/seq_divider.sv | 68 ++++++
 rtl/pbit_factor_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pbit_factor_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_factor_pkg.sv
// Shared definitions for the p-bit factoring controller: FSM encoding and
// the small constants used for candidate forcing and the even-N shortcut.
package pbit_factor_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SAMPLE = 2'd1,
        DIVIDE      = 2'd2,
        CHECK       = 2'd3
    } fsm_state_t;

    localparam int MIN_CAND    = 3;
    localparam int EVEN_FACTOR = 2;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, N_W cycles in total. The first
// bit is resolved in the start cycle from the input operands directly.
module seq_divider #(
    parameter int N_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [N_W-1:0] i_dividend,
    input  logic [N_W-1:0] i_divisor,
    output logic           o_busy,
    output logic           o_done,
    output logic [N_W-1:0] o_quotient,
    output logic [N_W-1:0] o_remainder
);
    localparam int C_W = $clog2(N_W);

    logic [N_W-1:0] r_rem;
    logic [N_W-1:0] r_quo;
    logic [N_W-1:0] r_dvs;
    logic [C_W-1:0] r_cnt;
    logic           r_done;

    // One restoring step: the sign of the trial difference decides the quotient bit.
    function automatic logic [2*N_W-1:0] div_step(
        input logic [N_W-1:0] rem,
        input logic [N_W-1:0] quo,
        input logic [N_W-1:0] dvs
    );
        logic [N_W:0] tmp;
        logic [N_W:0] diff;
        tmp  = {rem, quo[N_W-1]};
        diff = tmp - {1'b0, dvs};
        if (!diff[N_W]) begin
            return {diff[N_W-1:0], quo[N_W-2:0], 1'b1};
        end else begin
            return {tmp[N_W-1:0], quo[N_W-2:0], 1'b0};
        end
    endfunction

    // Iteration registers and the end-of-division pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= {N_W{1'b0}};
            r_quo  <= {N_W{1'b0}};
            r_dvs  <= {N_W{1'b0}};
            r_cnt  <= {C_W{1'b0}};
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                {r_rem, r_quo} <= div_step({N_W{1'b0}}, i_dividend, i_divisor);
                r_dvs          <= i_divisor;
                r_cnt          <= C_W'(N_W - 1);
            end else if (r_cnt != {C_W{1'b0}}) begin
                {r_rem, r_quo} <= div_step(r_rem, r_quo, r_dvs);
                r_cnt          <= r_cnt - C_W'(32'd1);
                r_done         <= (r_cnt == C_W'(32'd1));
            end
        end
    end

    assign o_busy      = (r_cnt != {C_W{1'b0}});
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/pbit_factor_ctrl.sv
// Controller that tries p-bit candidates as trial divisors of N until a factor
// is found or the sample limit is reached. Define FACTOR_EVEN_CHECK_EN to
// short-cut even N >= 4 to the factor pair (2, N/2) without sampling.
module pbit_factor_ctrl
    import pbit_factor_pkg::*;
#(
    parameter int N_W   = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_W-1:0]   i_N,
    input  logic [CNT_W-1:0] i_max_count,
    input  logic             i_start,
    input  logic [N_W/2-1:0] i_cand,
    input  logic             i_cand_valid,
    output logic             o_cand_ready,
    output logic             o_target_y,
    output logic [N_W/2-1:0] o_X,
    output logic [N_W/2-1:0] o_Y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic [CNT_W-1:0] o_count
);
    localparam int F_W = N_W / 2;
    localparam logic [F_W-1:0] C_MIN  = F_W'(MIN_CAND);
    localparam logic [F_W-1:0] C_EVEN = F_W'(EVEN_FACTOR);
    localparam logic [F_W-1:0] C_ONE  = F_W'(32'd1);

    fsm_state_t       r_state;
    fsm_state_t       w_next_state;
    logic [N_W-1:0]   r_n;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_count;
    logic [F_W-1:0]   r_x;
    logic [F_W-1:0]   r_y;
    logic             r_found;
    logic             r_target_y;
    logic             r_done;
    logic             r_busy;
    logic             r_cand_ready;
    logic             r_even;

    logic [F_W-1:0]   w_cand;
    logic             w_trivial;
    logic             w_even;
    logic             w_accept_start;
    logic             w_hs;
    logic             w_even_hit;
    logic             w_found_hit;
    logic             w_limit_hit;
    logic             w_toggle;
    logic             w_div_busy;
    logic             w_div_done;
    logic [N_W-1:0]   w_div_quo;
    logic [N_W-1:0]   w_div_rem;

    assign w_trivial = (i_N < N_W'(32'd4)) || (i_max_count == {CNT_W{1'b0}});

`ifdef FACTOR_EVEN_CHECK_EN
    assign w_even = ~i_N[0];
`else
    assign w_even = 1'b0;
`endif

    // Candidates are forced odd; anything that would collapse to 1 becomes 3.
    assign w_cand = (i_cand[F_W-1:1] == {(F_W-1){1'b0}}) ? C_MIN : (i_cand | C_ONE);

    seq_divider #(
        .N_W (N_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_hs),
        .i_dividend  (r_n),
        .i_divisor   ({{(N_W-F_W){1'b0}}, w_cand}),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        w_next_state   = r_state;
        w_accept_start = 1'b0;
        w_hs           = 1'b0;
        w_even_hit     = 1'b0;
        w_found_hit    = 1'b0;
        w_limit_hit    = 1'b0;
        w_toggle       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept_start = 1'b1;
                    if (w_trivial) begin
                        w_next_state = IDLE;
                    end else if (w_even) begin
                        w_next_state = CHECK;
                    end else begin
                        w_next_state = WAIT_SAMPLE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT_SAMPLE: begin
                if (i_cand_valid && r_cand_ready) begin
                    w_hs         = 1'b1;
                    w_next_state = DIVIDE;
                end else begin
                    w_next_state = WAIT_SAMPLE;
                end
            end
            DIVIDE: begin
                if (w_div_done && !w_div_busy) begin
                    w_next_state = CHECK;
                end else begin
                    w_next_state = DIVIDE;
                end
            end
            CHECK: begin
                w_next_state = IDLE;
                if (r_even) begin
                    w_even_hit = 1'b1;
                end else if ((w_div_rem == {N_W{1'b0}}) && (w_div_quo > N_W'(32'd1))) begin
                    w_found_hit = 1'b1;
                end else if (r_count == r_max) begin
                    w_limit_hit = 1'b1;
                end else begin
                    w_toggle     = 1'b1;
                    w_next_state = WAIT_SAMPLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Run context, factor registers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n          <= {N_W{1'b0}};
            r_max        <= {CNT_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_x          <= {F_W{1'b0}};
            r_y          <= {F_W{1'b0}};
            r_found      <= 1'b0;
            r_target_y   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_cand_ready <= 1'b0;
            r_even       <= 1'b0;
        end else begin
            r_busy       <= (w_next_state != IDLE);
            r_cand_ready <= (w_next_state == WAIT_SAMPLE);
            r_done       <= (w_accept_start && w_trivial) || w_even_hit || w_found_hit || w_limit_hit;
            if (w_accept_start) begin
                r_n        <= i_N;
                r_max      <= i_max_count;
                r_count    <= {CNT_W{1'b0}};
                r_found    <= 1'b0;
                r_target_y <= 1'b0;
                r_x        <= C_MIN;
                r_y        <= C_MIN;
                r_even     <= w_even;
            end else if (w_hs) begin
                if (r_target_y) begin
                    r_y <= w_cand;
                end else begin
                    r_x <= w_cand;
                end
                r_count <= r_count + CNT_W'(32'd1);
            end else if (w_even_hit) begin
                r_x     <= C_EVEN;
                r_y     <= r_n[F_W:1];
                r_found <= 1'b1;
            end else if (w_found_hit) begin
                // The quotient lands in whichever register was not just sampled.
                if (r_target_y) begin
                    r_x <= w_div_quo[F_W-1:0];
                end else begin
                    r_y <= w_div_quo[F_W-1:0];
                end
                r_found <= 1'b1;
            end else if (w_toggle) begin
                r_target_y <= ~r_target_y;
            end else begin
                r_found <= r_found;
            end
        end
    end

    assign o_cand_ready = r_cand_ready;
    assign o_target_y   = r_target_y;
    assign o_X          = r_x;
    assign o_Y          = r_y;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_found      = r_found;
    assign o_count      = r_count;

endmodule

// File: tb/tb_pbit_factor_ctrl.sv
// Self-checking bench for pbit_factor_ctrl at N_W=8, with directed scenarios
// and randomized jobs checked against an arithmetic reference model.
module tb_pbit_factor_ctrl;
    localparam int NW    = 8;
    localparam int FW    = NW / 2;
    localparam int FMOD  = 1 << FW;
    localparam int LAT_S = NW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NW-1:0] i_N = '0;
    logic [31:0]   i_max_count = '0;
    logic          i_start = 1'b0;
    logic [FW-1:0] i_cand = '0;
    logic          i_cand_valid = 1'b0;
    logic          o_cand_ready, o_target_y, o_busy, o_done, o_found;
    logic [FW-1:0] o_X, o_Y;
    logic [31:0]   o_count;

    int n_vec = 0;
    int n_err = 0;
    int cands[16];

    pbit_factor_ctrl #(.N_W(NW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_N(i_N), .i_max_count(i_max_count),
        .i_start(i_start), .i_cand(i_cand), .i_cand_valid(i_cand_valid),
        .o_cand_ready(o_cand_ready), .o_target_y(o_target_y), .o_X(o_X), .o_Y(o_Y),
        .o_busy(o_busy), .o_done(o_done), .o_found(o_found), .o_count(o_count)
    );

    always #5 clk = ~clk;

    // Reference: walk the candidate list with plain division, alternating X/Y.
    function automatic void model(input int n, input int mx, input int nc,
                                  output int ex, output int ey, output int ef,
                                  output int ec, output int elat);
        int t, c;
        ex = 3; ey = 3; ef = 0; ec = 0; elat = 1; t = 0;
        if (n < 4 || mx == 0) return;
`ifdef FACTOR_EVEN_CHECK_EN
        if (n % 2 == 0) begin
            ex = 2; ey = (n / 2) % FMOD; ef = 1; elat = 2;
            return;
        end
`endif
        elat = LAT_S;
        for (int i = 0; i < nc; i++) begin
            c = (cands[i] / 2 == 0) ? 3 : (cands[i] | 1);
            if (t == 1) ey = c; else ex = c;
            ec++;
            if (n % c == 0 && n / c > 1) begin
                ef = 1;
                if (t == 1) ex = (n / c) % FMOD; else ey = (n / c) % FMOD;
                return;
            end
            if (ec == mx) return;
            t = 1 - t;
        end
        elat = -1;
    endfunction

    // Pulse start; lat = cycles to o_done, or -1 if the DUT asks for a sample.
    task automatic start_job(input int n, input int mx, output int lat);
        int k;
        @(negedge clk);
        i_N = NW'(n); i_max_count = 32'(mx); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        k = 1;
        while (!o_done && !o_cand_ready && k < 40) begin @(negedge clk); k++; end
        lat = o_done ? k : -1;
    endtask

    // Offer one candidate from a negedge; lat = cycles from handshake to o_done, or -1.
    task automatic offer(input int c, output int lat);
        int k;
        i_cand = FW'(c); i_cand_valid = 1'b1;
        @(negedge clk);
        i_cand_valid = 1'b0;
        k = 1;
        while (!o_done && !o_cand_ready && k < 40) begin @(negedge clk); k++; end
        lat = o_done ? k : -1;
    endtask

    task automatic run_job(input int n, input int mx, input int nc, output int lat);
        int hs;
        hs = 0;
        start_job(n, mx, lat);
        while (lat < 0 && o_cand_ready && hs < nc) begin
            offer(cands[hs], lat);
            hs++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (o_X !== 4'd0) begin n_err++; $display("FAIL reset_X got=%0d exp=0", o_X); end
        n_vec++; if (o_Y !== 4'd0) begin n_err++; $display("FAIL reset_Y got=%0d exp=0", o_Y); end
        n_vec++; if (o_count !== 32'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_vec++; if ({o_busy, o_done, o_found, o_cand_ready, o_target_y} !== 5'b0)
            begin n_err++; $display("FAIL reset_flags got=%b exp=00000", {o_busy, o_done, o_found, o_cand_ready, o_target_y}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        cands[0] = 3;
        run_job(15, 10, 1, lat);
        n_vec++; if (lat !== LAT_S) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT_S); end
        n_vec++; if ({o_found, o_X, o_Y} !== {1'b1, 4'd3, 4'd5})
            begin n_err++; $display("FAIL basic_result got=%0d/%0d/%0d exp=1/3/5", o_found, o_X, o_Y); end
        n_vec++; if (o_count !== 32'd1) begin n_err++; $display("FAIL basic_count got=%0d exp=1", o_count); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got=%0d exp=0", o_busy); end
        repeat (3) @(negedge clk);
        n_vec++; if ({o_done, o_found, o_X, o_Y, o_count} !== {1'b0, 1'b1, 4'd3, 4'd5, 32'd1})
            begin n_err++; $display("FAIL idle_hold got=%0d/%0d/%0d/%0d/%0d exp=0/1/3/5/1", o_done, o_found, o_X, o_Y, o_count); end
    endtask

    task automatic test_toggle();
        int lat;
        start_job(35, 10, lat);
        offer(0, lat);
        n_vec++; if ({o_target_y, o_X, o_count} !== {1'b1, 4'd3, 32'd1})
            begin n_err++; $display("FAIL toggle_first got=%0d/%0d/%0d exp=1/3/1", o_target_y, o_X, o_count); end
        offer(7, lat);
        n_vec++; if (lat !== LAT_S) begin n_err++; $display("FAIL toggle_latency got=%0d exp=%0d", lat, LAT_S); end
        n_vec++; if ({o_found, o_X, o_Y, o_count} !== {1'b1, 4'd5, 4'd7, 32'd2})
            begin n_err++; $display("FAIL toggle_result got=%0d/%0d/%0d/%0d exp=1/5/7/2", o_found, o_X, o_Y, o_count); end
    endtask

    task automatic test_limit();
        int lat;
        int seen;
        start_job(143, 2, lat);
        offer(5, lat);
        offer(9, lat);
        n_vec++; if (lat !== LAT_S) begin n_err++; $display("FAIL limit_latency got=%0d exp=%0d", lat, LAT_S); end
        n_vec++; if ({o_found, o_X, o_Y, o_count} !== {1'b0, 4'd5, 4'd9, 32'd2})
            begin n_err++; $display("FAIL limit_result got=%0d/%0d/%0d/%0d exp=0/5/9/2", o_found, o_X, o_Y, o_count); end
        seen = 0;
        i_cand = 4'd11; i_cand_valid = 1'b1;
        repeat (5) begin @(negedge clk); if (o_cand_ready) seen++; end
        i_cand_valid = 1'b0;
        n_vec++; if ({seen[3:0], o_count, o_X, o_Y} !== {4'd0, 32'd2, 4'd5, 4'd9})
            begin n_err++; $display("FAIL limit_ignore got=ready%0d/%0d/%0d/%0d exp=0/2/5/9", seen, o_count, o_X, o_Y); end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_job(21, 5, lat);
        i_cand = 4'd5; i_cand_valid = 1'b1;
        @(negedge clk); i_cand_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if ({o_busy, o_X} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL mid_pre got=%0d/%0d exp=1/5", o_busy, o_X); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({o_X, o_Y, o_count, o_busy, o_done, o_found, o_cand_ready, o_target_y} !== 45'd0)
            begin n_err++; $display("FAIL mid_reset got=%0d/%0d/%0d/%b exp=0/0/0/00000", o_X, o_Y, o_count, {o_busy, o_done, o_found, o_cand_ready, o_target_y}); end
        @(negedge clk); rst = 1'b1;
        cands[0] = 3;
        run_job(21, 5, 1, lat);
        n_vec++; if ({lat[7:0], o_found, o_X, o_Y} !== {8'(LAT_S), 1'b1, 4'd3, 4'd7})
            begin n_err++; $display("FAIL mid_restart got=%0d/%0d/%0d/%0d exp=%0d/1/3/7", lat, o_found, o_X, o_Y, LAT_S); end
    endtask

    task automatic test_trivial();
        int lat;
        run_job(2, 5, 0, lat);
        n_vec++; if ({lat[7:0], o_found, o_count, o_busy} !== {8'd1, 1'b0, 32'd0, 1'b0})
            begin n_err++; $display("FAIL small_n got=%0d/%0d/%0d/%0d exp=1/0/0/0", lat, o_found, o_count, o_busy); end
        run_job(15, 0, 0, lat);
        n_vec++; if ({lat[7:0], o_found, o_count} !== {8'd1, 1'b0, 32'd0})
            begin n_err++; $display("FAIL zero_max got=%0d/%0d/%0d exp=1/0/0", lat, o_found, o_count); end
        start_job(15, 3, lat);
        i_N = 8'd2; i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        n_vec++; if ({o_busy, o_cand_ready, o_done} !== 3'b110)
            begin n_err++; $display("FAIL start_busy got=%b exp=110", {o_busy, o_cand_ready, o_done}); end
        offer(3, lat);
        n_vec++; if ({lat[7:0], o_found, o_X, o_Y} !== {8'(LAT_S), 1'b1, 4'd3, 4'd5})
            begin n_err++; $display("FAIL start_busy_result got=%0d/%0d/%0d/%0d exp=%0d/1/3/5", lat, o_found, o_X, o_Y, LAT_S); end
    endtask

    task automatic test_even();
        int lat, ex, ey, ef, ec, el;
        cands[0] = 11;
        model(22, 4, 1, ex, ey, ef, ec, el);
        start_job(22, 4, lat);
`ifndef FACTOR_EVEN_CHECK_EN
        n_vec++; if ({lat[7:0], o_cand_ready} !== {8'hFF, 1'b1})
            begin n_err++; $display("FAIL even_sampling got=%0d/%0d exp=-1/1", lat, o_cand_ready); end
        offer(11, lat);
`endif
        n_vec++; if (lat !== el) begin n_err++; $display("FAIL even_latency got=%0d exp=%0d", lat, el); end
        n_vec++; if ({o_found, o_X, o_Y, o_count} !== {ef[0], 4'(ex), 4'(ey), 32'(ec)})
            begin n_err++; $display("FAIL even_result got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", o_found, o_X, o_Y, o_count, ef, ex, ey, ec); end
    endtask

    task automatic test_random();
        int n, mx, lat, ex, ey, ef, ec, el;
        for (int j = 0; j < 25; j++) begin
            n  = $urandom_range(0, 255);
            mx = $urandom_range(0, 5);
            for (int i = 0; i < mx; i++) cands[i] = $urandom_range(0, 15);
            model(n, mx, mx, ex, ey, ef, ec, el);
            run_job(n, mx, mx, lat);
            n_vec++; if (lat !== el) begin n_err++; $display("FAIL rnd_latency N=%0d got=%0d exp=%0d", n, lat, el); end
            n_vec++; if (o_found !== ef[0]) begin n_err++; $display("FAIL rnd_found N=%0d got=%0d exp=%0d", n, o_found, ef); end
            n_vec++; if ({o_X, o_Y} !== {4'(ex), 4'(ey)})
                begin n_err++; $display("FAIL rnd_xy N=%0d got=%0d/%0d exp=%0d/%0d", n, o_X, o_Y, ex, ey); end
            n_vec++; if (o_count !== 32'(ec)) begin n_err++; $display("FAIL rnd_count N=%0d got=%0d exp=%0d", n, o_count, ec); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_limit();
        test_reset_mid();
        test_trivial();
        test_even();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
